sdram_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single SDRAM controller port between the CPU memory interface (port 0) and a second bus master (port 1, e.g. DMA or boot copier). It sits inside the SoC between the requesters and the SDRAM controller. It grants round-robin, latches the winning request into registers, and forwards the controller's completion back to the granted requester. A configurable watchdog terminates transactions the controller never acknowledges.

---
 rtl/sdram_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller port between two bus masters.
// Round-robin grant, registered request latch, zero-latency completion return, watchdog.
module sdram_port_arbiter #(
  parameter int unsigned ADDR_W         = 24,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              p0_valid,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  input  logic [3:0]        p0_wstrb,
  output logic              p0_ready,
  output logic [31:0]       p0_rdata,

  input  logic              p1_valid,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  input  logic [3:0]        p1_wstrb,
  output logic              p1_ready,
  output logic [31:0]       p1_rdata,

  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,

  output logic [1:0]        grant,
  output logic              timeout_err
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_BUSY   = 2'd1;
  localparam logic [1:0]  ST_TURN   = 2'd2;
  localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT_CYCLES);
  localparam logic        WDOG_EN   = (TIMEOUT_CYCLES != 0);

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic [1:0]        grant_q, grant_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [15:0]       wdog_q, wdog_d;

  logic any_req;
  logic sel_p1;
  logic busy;
  logic done_mem;
  logic done_wdog;
  logic done;

  // Port 1 wins when alone, or in contention when port 0 was served last.
  assign any_req   = p0_valid | p1_valid;
  assign sel_p1    = p1_valid & (~p0_valid | ~last_q);
  assign busy      = (state_q == ST_BUSY);
  assign done_mem  = busy & mem_ready;
  assign done_wdog = WDOG_EN & busy & ~mem_ready & (wdog_q == TIMEOUT_V);
  assign done      = done_mem | done_wdog;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    mem_valid_d = mem_valid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wdog_d      = wdog_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d     = ST_BUSY;
          mem_valid_d = 1'b1;
          grant_d     = sel_p1 ? 2'b10 : 2'b01;
          addr_d      = sel_p1 ? p1_addr  : p0_addr;
          wdata_d     = sel_p1 ? p1_wdata : p0_wdata;
          wstrb_d     = sel_p1 ? p1_wstrb : p0_wstrb;
          wdog_d      = 16'd0;
        end
      end
      ST_BUSY: begin
        if (done) begin
          state_d     = ST_TURN;
          mem_valid_d = 1'b0;
          grant_d     = 2'b00;
          last_d      = grant_q[1];
        end else if (WDOG_EN) begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        mem_valid_d = 1'b0;
        grant_d     = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      grant_q     <= 2'b00;
      mem_valid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      wdog_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      mem_valid_q <= mem_valid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wdog_q      <= wdog_d;
    end
  end

  // Completion returns in the same cycle; a watchdog exit carries zero data.
  assign p0_ready    = done & grant_q[0];
  assign p1_ready    = done & grant_q[1];
  assign p0_rdata    = (done_mem & grant_q[0]) ? mem_rdata : 32'h0;
  assign p1_rdata    = (done_mem & grant_q[1]) ? mem_rdata : 32'h0;
  assign timeout_err = done_wdog;

  assign mem_valid = mem_valid_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed and random transactions checked against
// a transaction-level model (round-robin pointer, latched request, completion cycle).
module tb_sdram_port_arbiter;

  localparam int AW = 24;
  localparam int T  = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          p0_valid, p1_valid;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [31:0]   p0_wdata, p1_wdata;
  logic [3:0]    p0_wstrb, p1_wstrb;
  logic          p0_ready, p1_ready;
  logic [31:0]   p0_rdata, p1_rdata;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic [1:0]    grant;
  logic          timeout_err;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.ADDR_W(AW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .resetn(resetn),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb),
    .p0_ready(p0_ready), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb),
    .p1_ready(p1_ready), .p1_rdata(p1_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_txn    = 0;
  int last_served = 1;
  int rdy_seen[2];

  logic          req_v[2];
  logic [AW-1:0] req_a[2];
  logic [31:0]   req_d[2];
  logic [3:0]    req_s[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    p0_valid = req_v[0]; p0_addr = req_a[0]; p0_wdata = req_d[0]; p0_wstrb = req_s[0];
    p1_valid = req_v[1]; p1_addr = req_a[1]; p1_wdata = req_d[1]; p1_wstrb = req_s[1];
  endtask

  task automatic new_req(input int p);
    req_v[p] = 1'b1;
    req_a[p] = AW'($urandom);
    req_d[p] = $urandom;
    req_s[p] = 4'($urandom);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    mem_ready = 1'b0;
    apply();
    #1;
    chk("idle_mem_valid", 32'(mem_valid), 32'd0);
    chk("idle_grant", 32'(grant), 32'd0);
    chk("idle_p1_ready", 32'(p1_ready), 32'd0);
  endtask

  // Called at a negedge while the DUT is IDLE; returns at the following IDLE negedge.
  // lat = BUSY cycle on which the controller answers (0 = never).
  task automatic serve(input int lat, input logic [31:0] rd, output int w);
    logic [AW-1:0] ea;
    logic [31:0]   ed;
    logic [3:0]    es;
    int            k;
    bit            fin, real_done, to;
    apply();
    #1;
    chk("idle_mem_valid", 32'(mem_valid), 32'd0);
    if (req_v[0] && req_v[1]) w = (last_served == 1) ? 0 : 1;
    else                      w = req_v[0] ? 0 : 1;
    ea = req_a[w]; ed = req_d[w]; es = req_s[w];
    k = 0; fin = 0; real_done = 0; to = 0;
    while (!fin) begin
      @(negedge clk);
      k++;
      // Requester changes its inputs while granted; they must not reach mem_*.
      req_a[w] = ~req_a[w];
      req_d[w] = $urandom;
      req_s[w] = ~req_s[w];
      apply();
      mem_ready = (k == lat);
      mem_rdata = (k == lat) ? rd : $urandom;
      #1;
      real_done = (k == lat);
      to        = (k == T + 1) && !real_done;
      fin       = real_done || to;
      chk("busy_mem_valid", 32'(mem_valid), 32'd1);
      chk("busy_grant", 32'(grant), (w == 0) ? 32'd1 : 32'd2);
      chk("busy_mem_addr", 32'(mem_addr), 32'(ea));
      chk("busy_mem_wdata", mem_wdata, ed);
      chk("busy_mem_wstrb", 32'(mem_wstrb), 32'(es));
      chk("p0_ready", 32'(p0_ready), 32'(fin && w == 0));
      chk("p1_ready", 32'(p1_ready), 32'(fin && w == 1));
      chk("p0_rdata", p0_rdata, (real_done && w == 0) ? rd : 32'h0);
      chk("p1_rdata", p1_rdata, (real_done && w == 1) ? rd : 32'h0);
      chk("timeout_err", 32'(timeout_err), 32'(to));
      if (p0_ready) rdy_seen[0]++;
      if (p1_ready) rdy_seen[1]++;
    end
    last_served = w;
    $display("txn %0d: port %0d addr=%h wdata=%h wstrb=%h busy_cycles=%0d timeout=%0d",
             n_txn, w, ea, ed, es, k, to);
    n_txn++;
    // TURN: winner's valid is still high, stray mem_ready must not complete anything.
    @(negedge clk);
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    chk("turn_mem_valid", 32'(mem_valid), 32'd0);
    chk("turn_grant", 32'(grant), 32'd0);
    chk("turn_p0_ready", 32'(p0_ready), 32'd0);
    chk("turn_p1_ready", 32'(p1_ready), 32'd0);
    chk("turn_timeout_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    req_v[w] = 1'b0;
    apply();
    #1;
    chk("post_turn_mem_valid", 32'(mem_valid), 32'd0);
  endtask

  initial begin
    int w;
    resetn = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    for (int p = 0; p < 2; p++) begin
      req_v[p] = 1'b0; req_a[p] = '0; req_d[p] = 32'h0; req_s[p] = 4'h0;
      rdy_seen[p] = 0;
    end
    apply();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_p0_ready", 32'(p0_ready), 32'd0);
    chk("rst_p1_rdata", p1_rdata, 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Saturated contention: both ports re-request immediately.
    new_req(0);
    new_req(1);
    for (int i = 0; i < 6; i++) begin
      serve($urandom_range(1, 5), $urandom, w);
      if (i < 4) new_req(w);
    end
    chk("contention_p0_readies", 32'(rdy_seen[0]), 32'd3);
    chk("contention_p1_readies", 32'(rdy_seen[1]), 32'd3);

    // Single read on port 0, controller answers 5 cycles after mem_valid.
    req_v[0] = 1'b1; req_a[0] = 24'h000100; req_d[0] = $urandom; req_s[0] = 4'h0;
    serve(6, 32'hCAFEBABE, w);

    // Turnaround: port 1 holds valid through TURN, then drops.
    new_req(1);
    serve(3, $urandom, w);
    idle_cycle();
    idle_cycle();

    // Watchdog: no answer, then answer on exactly the expiry cycle.
    new_req(1); req_s[1] = 4'hF;
    serve(0, 32'h0, w);
    idle_cycle();
    new_req(1); req_s[1] = 4'hF;
    serve(T + 1, 32'h12345678, w);

    // Random traffic including late and missing answers.
    for (int i = 0; i < 40; i++) begin
      if (!req_v[0] && $urandom_range(0, 1) == 1) new_req(0);
      if (!req_v[1] && $urandom_range(0, 1) == 1) new_req(1);
      if (!req_v[0] && !req_v[1]) new_req($urandom_range(0, 1));
      serve($urandom_range(0, T + 3), $urandom, w);
    end
    while (req_v[0] || req_v[1]) serve($urandom_range(1, 4), $urandom, w);

    // Reset two cycles into BUSY: asynchronous clear, no ready issued.
    new_req(1);
    apply();
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_mem_valid", 32'(mem_valid), 32'd1);
    resetn = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = $urandom;
    #1;
    chk("async_rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("async_rst_grant", 32'(grant), 32'd0);
    chk("async_rst_p1_ready", 32'(p1_ready), 32'd0);
    chk("async_rst_p1_rdata", p1_rdata, 32'd0);
    req_v[1] = 1'b0;
    apply();
    repeat (2) @(negedge clk);
    mem_ready = 1'b0;
    resetn = 1'b1;
    last_served = 1;
    new_req(0);
    new_req(1);
    serve(2, $urandom, w);
    chk("post_rst_first_winner", 32'(w), 32'd0);
    serve(2, $urandom, w);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
